// File: rtl/dct_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module      : dct_matmul_engine
// Description : N x N signed matrix multiplier (A*B or A*B^T) built from N
//               parallel MAC lanes, one result row every N cycles, with
//               round-half-up right shift and saturation to DW bits.
// Revision    : 1.0 - initial release
// ============================================================================
module dct_matmul_engine #(
  parameter int N     = 4,
  parameter int DW    = 13,
  parameter int SHIFT = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          val_input,
  input  logic                          transpose_b,
  input  logic [N-1:0][N-1:0][DW-1:0]   A1,
  input  logic [N-1:0][N-1:0][DW-1:0]   B1,
  output logic                          busy,
  output logic                          val_output,
  output logic [N-1:0][N-1:0][DW-1:0]   Res1
);

  localparam int IW   = $clog2(N);
  localparam int PW   = 2 * DW;
  localparam int ACCW = 2 * DW + $clog2(N);

  localparam logic signed [ACCW-1:0] c_max = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] c_min = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                         r_state;
  state_t                         w_next;
  logic [IW-1:0]                  r_i;
  logic [IW-1:0]                  r_k;
  logic                           r_tb;
  logic [N-1:0][N-1:0][DW-1:0]    r_a;
  logic [N-1:0][N-1:0][DW-1:0]    r_b;
  logic [N-1:0][N-1:0][DW-1:0]    r_res;
  logic signed [ACCW-1:0]         r_acc [N];
  logic signed [ACCW-1:0]         w_sum [N];
  logic signed [DW-1:0]           w_sat [N];
  logic                           w_last_k;
  logic                           w_last_i;

  assign w_last_k = (r_k == IW'(N-1));
  assign w_last_i = (r_i == IW'(N-1));
  assign Res1     = r_res;

  // One MAC lane per output column; the lane also rounds and saturates its
  // running sum so the final value is ready on the last k edge of a row.
  for (genvar j = 0; j < N; j++) begin : g_lane
    logic signed [DW-1:0]   w_a;
    logic signed [DW-1:0]   w_b;
    logic signed [PW-1:0]   w_prod;
    logic signed [ACCW-1:0] w_rnd;

    assign w_a    = r_a[r_i][r_k];
    assign w_b    = r_tb ? r_b[j][r_k] : r_b[r_k][j];
    assign w_prod = w_a * w_b;
    assign w_sum[j] = r_acc[j] + {{(ACCW-PW){w_prod[PW-1]}}, w_prod};

    if (SHIFT == 0) begin : g_noround
      assign w_rnd = w_sum[j];
    end else begin : g_round
      // Half-LSB bias before the arithmetic shift gives round-half-up.
      localparam logic signed [ACCW-1:0] c_half = ACCW'(1) << (SHIFT - 1);
      logic signed [ACCW-1:0] w_biased;
      assign w_biased = w_sum[j] + c_half;
      assign w_rnd    = w_biased >>> SHIFT;
    end

    assign w_sat[j] = (w_rnd > c_max) ? c_max[DW-1:0] :
                      (w_rnd < c_min) ? c_min[DW-1:0] : w_rnd[DW-1:0];
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_next     = r_state;
    busy       = (r_state != S_IDLE);
    val_output = (r_state == S_DONE);
    case (r_state)
      S_IDLE:    if (val_input) w_next = S_COMPUTE;
      S_COMPUTE: if (w_last_k && w_last_i) w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Operand capture, MAC accumulation, row write-back and index sequencing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i   <= '0;
      r_k   <= '0;
      r_tb  <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      for (int j = 0; j < N; j++) r_acc[j] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (val_input) begin
            r_a  <= A1;
            r_b  <= B1;
            r_tb <= transpose_b;
            r_i  <= '0;
            r_k  <= '0;
            for (int j = 0; j < N; j++) r_acc[j] <= '0;
          end
        end
        S_COMPUTE: begin
          if (w_last_k) begin
            for (int j = 0; j < N; j++) begin
              r_res[r_i][j] <= w_sat[j];
              r_acc[j]      <= '0;
            end
            r_k <= '0;
            r_i <= w_last_i ? '0 : r_i + IW'(1);
          end else begin
            for (int j = 0; j < N; j++) r_acc[j] <= w_sum[j];
            r_k <= r_k + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_matmul_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_dct_matmul_engine
// Description : Directed, table-driven bench for dct_matmul_engine (SHIFT=0
//               and SHIFT=2 instances sharing operands and reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dct_matmul_engine;

  logic                     clk;
  logic                     reset;
  logic                     vi0, vi1;
  logic                     tr;
  logic [3:0][3:0][12:0]    a_in, b_in;
  logic                     busy0, busy1, vo0, vo1;
  logic [3:0][3:0][12:0]    res0, res1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int op;
    int r;
    int c;
    int exp;
  } chk_t;

  chk_t tab[$];

  dct_matmul_engine #(.N(4), .DW(13), .SHIFT(0)) u_dut0 (
    .clk(clk), .reset(reset), .val_input(vi0), .transpose_b(tr),
    .A1(a_in), .B1(b_in), .busy(busy0), .val_output(vo0), .Res1(res0));

  dct_matmul_engine #(.N(4), .DW(13), .SHIFT(2)) u_dut1 (
    .clk(clk), .reset(reset), .val_input(vi1), .transpose_b(tr),
    .A1(a_in), .B1(b_in), .busy(busy1), .val_output(vo1), .Res1(res1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mval(input int m, input int r, input int c);
    case (m)
      0:       return r * 4 + c;
      1:       return 4095;
      2:       return -4096;
      3:       return (r == c) ? 6 : 0;
      4:       return (r == c) ? -6 : 0;
      default: return (r == c) ? 1 : 0;
    endcase
  endfunction

  task automatic set_ops(input int am, input int bm);
    int v;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        v = mval(am, r, c); a_in[r][c] = v[12:0];
        v = mval(bm, r, c); b_in[r][c] = v[12:0];
      end
  endtask

  function automatic int rd(input int sel, input int r, input int c);
    logic signed [12:0] e;
    e = (sel == 0) ? res0[r][c] : res1[r][c];
    return int'(e);
  endfunction

  function automatic int nonzero_count();
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        if (res0[r][c] != 13'd0) n++;
        if (res1[r][c] != 13'd0) n++;
      end
    return n;
  endfunction

  task automatic set_vi(input int sel, input logic v);
    if (sel == 0) vi0 = v; else vi1 = v;
  endtask

  // Launch one operation and watch 24 cycles after the capture edge.
  task automatic run_op(input int sel, input int am, input int bm, input logic t,
                        input int inj_at, input int rst_at,
                        output int first_vo, output int pulses);
    logic b, v;
    set_ops(am, bm);
    tr = t;
    @(posedge clk); #1;
    set_vi(sel, 1'b1);
    @(posedge clk); #1;
    set_vi(sel, 1'b0);
    b = (sel == 0) ? busy0 : busy1;
    check("busy_after_capture", int'(b), 1);
    first_vo = -1;
    pulses   = 0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      v = (sel == 0) ? vo0 : vo1;
      if (v) begin
        pulses++;
        if (first_vo < 0) first_vo = c;
      end
      if (c == inj_at) begin
        set_ops(1, 1);
        tr = ~t;
        set_vi(sel, 1'b1);
      end
      if (c == inj_at + 1) set_vi(sel, 1'b0);
      if (c == rst_at) begin
        reset = 1'b1;
        #1;
        check("rst_busy", int'(busy0), 0);
        check("rst_valout", int'(vo0), 0);
        check("rst_res_nonzero", nonzero_count(), 0);
        #1;
        reset = 1'b0;
      end
    end
  endtask

  task automatic check_tab(input int tag, input int sel, input string name);
    foreach (tab[n])
      if (tab[n].op == tag)
        check($sformatf("%s[%0d][%0d]", name, tab[n].r, tab[n].c),
              rd(sel, tab[n].r, tab[n].c), tab[n].exp);
  endtask

  task automatic check_all(input int sel, input int am, input int dval, input int oval,
                           input string name);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        check($sformatf("%s[%0d][%0d]", name, r, c), rd(sel, r, c),
              (am == 0 || r == c) ? dval : oval);
  endtask

  initial begin
    int fv, np;
    int prod [4][4] = '{'{56, 62, 68, 74}, '{152, 174, 196, 218},
                        '{248, 286, 324, 362}, '{344, 398, 452, 506}};

    // Hand-computed A*B for the 0..15 ramp (tag 0) and A*B^T entries (tag 1).
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tab.push_back('{0, r, c, prod[r][c]});
    tab.push_back('{1, 0, 0, 14});
    tab.push_back('{1, 0, 1, 38});
    tab.push_back('{1, 1, 0, 38});
    tab.push_back('{1, 0, 3, 86});
    tab.push_back('{1, 1, 2, 214});
    tab.push_back('{1, 2, 3, 518});
    tab.push_back('{1, 3, 2, 518});
    tab.push_back('{1, 3, 3, 734});

    vi0 = 1'b0; vi1 = 1'b0; tr = 1'b0;
    a_in = '0; b_in = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy0", int'(busy0), 0);
    check("reset_busy1", int'(busy1), 0);
    check("reset_vo0", int'(vo0), 0);
    check("reset_res_nonzero", nonzero_count(), 0);
    reset = 1'b0;

    // Ramp * ramp, plain product.
    run_op(0, 0, 0, 1'b0, -10, -10, fv, np);
    check("ab_latency", fv, 16);
    check("ab_pulses", np, 1);
    check_tab(0, 0, "ab");

    // Ramp * ramp^T: symmetric result.
    run_op(0, 0, 0, 1'b1, -10, -10, fv, np);
    check("abt_latency", fv, 16);
    check_tab(1, 0, "abt");

    // Positive and negative saturation.
    run_op(0, 1, 1, 1'b0, -10, -10, fv, np);
    check("satp_latency", fv, 16);
    check_all(0, 0, 4095, 4095, "sat_pos");
    run_op(0, 1, 2, 1'b0, -10, -10, fv, np);
    check_all(0, 0, -4096, -4096, "sat_neg");

    // Request during COMPUTE with other operands is ignored.
    run_op(0, 0, 0, 1'b0, 5, -10, fv, np);
    check("inj_latency", fv, 16);
    check("inj_pulses", np, 1);
    check_tab(0, 0, "inj");

    // Reset in the middle of COMPUTE aborts; then a fresh run completes.
    run_op(0, 0, 0, 1'b0, -10, 8, fv, np);
    check("abort_pulses", np, 0);
    run_op(0, 0, 0, 1'b1, -10, -10, fv, np);
    check("after_abort_latency", fv, 16);
    check("after_abort_pulses", np, 1);
    check_tab(1, 0, "after_abort");

    // SHIFT=2 instance: 6/4 rounds to 2, -6/4 rounds half-up to -1.
    run_op(1, 3, 5, 1'b0, -10, -10, fv, np);
    check("shift_latency", fv, 16);
    check_all(1, 1, 2, 0, "shift_pos");
    run_op(1, 4, 5, 1'b0, -10, -10, fv, np);
    check_all(1, 1, -1, 0, "shift_neg");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dct_matmul_engine.md
DCT_MATMUL_ENGINE -- requirements
Module: dct_matmul_engine

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset, on ports clk and reset.
REQ-002 Parameter N SHALL default to 4 and set the matrix dimension (N x N); legal range is 2..16.
REQ-003 Parameter DW SHALL default to 13 and set the data width (signed two's complement) of every element in and out.
REQ-004 Parameter SHIFT SHALL default to 0 and set the rounding right-shift applied to each result; legal range is 0..DW.
REQ-005 clk  in  1  Rising-edge clock.
REQ-006 reset  in  1  Asynchronous active-high reset.
REQ-007 val_input  in  1  Request; sampled only in IDLE.
REQ-008 transpose_b  in  1  Mode select: 0 computes A*B, 1 computes A*B^T; sampled with val_input.
REQ-009 A1  in  N x N x DW  Operand A, indexed [row][col].
REQ-010 B1  in  N x N x DW  Operand B, indexed [row][col].
REQ-011 busy  out  1  High whenever state is not IDLE.
REQ-012 val_output  out  1  One-cycle completion pulse.
REQ-013 Res1  out  N x N x DW  Registered result matrix.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, COMPUTE and DONE.
REQ-015 In IDLE, on a rising edge with val_input=1, the block SHALL capture A1, B1 and transpose_b into internal registers, clear the row index i, the k index and all accumulators, and enter COMPUTE. Later changes on A1 or B1 SHALL have no effect on the result.
REQ-016 COMPUTE SHALL use N parallel MAC lanes. On each edge, lane j SHALL add A[i][k]*Bsel[k][j] to its accumulator, where Bsel[k][j] = B[k][j] when transpose_b=0 and B[j][k] when transpose_b=1. On the same edge k SHALL increment.
REQ-017 The accumulator width SHALL be 2*DW + clog2(N) bits, so accumulation never overflows internally.
REQ-018 When k = N-1, the edge SHALL:
  - write the final value of every lane, after rounding and saturation, into Res1[i][j];
  - clear the accumulators, set k to 0 and increment i.
REQ-019 When i = N-1 and k = N-1, the edge SHALL complete row N-1 and move to DONE. COMPUTE therefore lasts exactly N*N edges.
REQ-020 Rounding: if SHIFT > 0, the block SHALL add 2^(SHIFT-1) and then arithmetic-shift right by SHIFT. If SHIFT = 0, the value SHALL pass unchanged.
REQ-021 Saturation: rounded values above 2^(DW-1)-1 SHALL clamp to 2^(DW-1)-1. Values below -2^(DW-1) SHALL clamp to -2^(DW-1).
REQ-022 val_output SHALL be 1 only in DONE, which lasts exactly one cycle, then the state SHALL return to IDLE.
REQ-023 val_output rises after the N*N-th rising edge following the capture edge; that is, latency is N*N cycles.
REQ-024 Res1 SHALL be fully valid when val_output is high. Res1 SHALL hold its value until overwritten row-by-row by the next operation.
REQ-025 val_input in COMPUTE or DONE SHALL be ignored, with no queuing. A new request is accepted in IDLE only, at the earliest one cycle after val_output.
REQ-026 Rows of Res1 that are not yet rewritten during an operation SHALL keep their previous values.

Reset
REQ-027 When reset is asserted, asynchronously:
  - state SHALL go to IDLE, with i = 0, k = 0 and all accumulators at 0;
  - busy = 0, val_output = 0 and every Res1 element = 0.
REQ-028 Reset asserted mid-COMPUTE or in DONE SHALL abort the operation. No val_output pulse SHALL follow, and the next val_input after reset deasserts SHALL start a fresh operation.

Verification
REQ-029 N=4, SHIFT=0, A = B = rows {0,1,2,3},{4,5,6,7},{8,9,10,11},{12,13,14,15}, transpose_b=0, one-cycle val_input -> val_output pulses once, 16 cycles after the capture edge. Res1 row0 = {56,62,68,74}, Res1[3][0] = 344, Res1[3][3] = 506.
REQ-030 Same operands with transpose_b=1 -> Res1[0][0] = 14, Res1[0][1] = 38; the result matrix is symmetric.
REQ-031 DW=13, all A and B elements = 4095 -> every Res1 element = 4095. With A = 4095 and B = -4096 -> every Res1 element = -4096 (saturation).
REQ-032 SHIFT=2, A = identity*6, B = identity -> diagonal = 2, off-diagonal = 0. A = identity*(-6) -> diagonal = -1 (round-half-up).
REQ-033 val_input pulsed at cycle 5 of COMPUTE with different operands -> the pulse is ignored; the result equals the first operands, and exactly one val_output occurs.
REQ-034 reset asserted at cycle 8 of COMPUTE -> busy = 0 and Res1 = 0 immediately; no val_output occurs. A new request then completes correctly after 16 cycles.
